seq_ctrl_fsm: RTL and testbench
===============================

Name: seq_ctrl_fsm

Overview:
- Sequencer core directly downstream of the AXI-Lite write decoder.
- Consumes the bank0 control and end-count write strobes and walks slot-table rows 0..endCnt.
- For each row it issues MM2S (source) and S2MM (destination) DMA commands and waits for completion.
- It then writes per-slot status and a cycle-count profile back into the bank1 slot table, and exports bank0 status for readback.

Parameters:
- INDEX_WIDTH, 2, slot index width (4 slots).
- SRC_ADDR_WIDTH, 32, source address width.
- SRC_SIZE_WIDTH, 26, source byte-count width.
- DST_ADDR_WIDTH, 32, destination address width.
- DST_SIZE_WIDTH, 26, destination byte-count width.
- SLOT_STATUS_WIDTH, 2, bank1 per-slot status width.
- PROFILE_WIDTH, 32, profile counter width.
- CONTROL_WIDTH, 4, bank0 control width.
- STATUS_WIDTH, 4, bank0 status width.
- CNT_WIDTH, INDEX_WIDTH, sequencer counter / end-count width.

Ports:
- clk  in  1  single clock for the block.
- reset  in  1  reset; asynchronous, active-low.
- inp_control  in  CONTROL_WIDTH  control data: [0]=start, [1]=stop, [2]=loop, [3]=clear.
- set_control  in  1  one-cycle strobe that applies inp_control.
- inp_endCnt  in  CNT_WIDTH  index of the last slot to run.
- set_endCnt  in  1  end-count write strobe.
- bank0_status  out  STATUS_WIDTH  [0]=busy, [1]=done, [2]=aborted, [3]=loop_active.
- cur_cnt  out  CNT_WIDTH  slot currently being processed.
- slot_rd_index  out  INDEX_WIDTH  slot-table read row (combinational read, data valid same cycle).
- slot_src_addr  in  SRC_ADDR_WIDTH  source address of the read row.
- slot_src_size  in  SRC_SIZE_WIDTH  source size of the read row.
- slot_des_addr  in  DST_ADDR_WIDTH  destination address of the read row.
- slot_des_size  in  DST_SIZE_WIDTH  destination size of the read row.
- slot_wr_index  out  INDEX_WIDTH  writeback row.
- slot_wr_status  out  SLOT_STATUS_WIDTH  status to write.
- slot_set_status  out  1  status write strobe.
- slot_wr_profile  out  PROFILE_WIDTH  profile value to write.
- slot_set_profile  out  1  profile write strobe.
- mm2s_cmd_valid  out  1  source DMA command valid.
- mm2s_cmd_ready  in  1  source DMA command ready.
- mm2s_cmd_addr  out  SRC_ADDR_WIDTH  source DMA command address.
- mm2s_cmd_size  out  SRC_SIZE_WIDTH  source DMA command size.
- s2mm_cmd_valid  out  1  destination DMA command valid.
- s2mm_cmd_ready  in  1  destination DMA command ready.
- s2mm_cmd_addr  out  DST_ADDR_WIDTH  destination DMA command address.
- s2mm_cmd_size  out  DST_SIZE_WIDTH  destination DMA command size.
- mm2s_done  in  1  one-cycle completion pulse from the source DMA.
- s2mm_done  in  1  one-cycle completion pulse from the destination DMA.

Behaviour:
- Reset (reset=0, async): state=IDLE; cnt, end_cnt, profile counter, sticky flags and all outputs =0. Reset mid-transfer abandons everything; no writeback is issued.
- States: IDLE, LOAD, CMD, WAIT, WB.
- IDLE:
  - set_endCnt loads end_cnt. It is ignored in every other state.
  - set_control with clear=1 clears done and aborted.
  - set_control with start=1: cnt=0, busy=1, loop_active=inp_control[2], done=0, aborted=0, next state LOAD. If start and clear arrive together, start wins; clear has no extra effect.
- LOAD (1 cycle): slot_rd_index=cnt; latch all four slot fields.
  - Abort pending -> IDLE with aborted=1, busy=0.
  - Both sizes 0 -> WB with status 2'b11 (skipped) and profile 0.
  - Otherwise -> CMD; profile counter=0.
- CMD:
  - mm2s_cmd_valid=1 only if src_size!=0; s2mm_cmd_valid=1 only if des_size!=0. Addr/size are driven from the latched values.
  - Each valid stays high until its own valid&ready handshake, then drops. The two channels are independent.
  - Once every required channel has handshaked -> WAIT.
- WAIT:
  - Sticky per-channel done flags capture mm2s_done/s2mm_done. A done pulse arriving already in CMD after that channel's handshake is also captured.
  - Once all required channels are done -> WB.
- Profile counter: increments every cycle in CMD and WAIT; saturates at all-ones, no wrap.
- WB (1 cycle): slot_set_status=1 and slot_set_profile=1, slot_wr_index=cnt, slot_wr_status=2'b10 (done) or 2'b11 (skipped).
  - Abort pending -> IDLE, aborted=1.
  - cnt!=end_cnt -> cnt+1, LOAD.
  - cnt==end_cnt and loop_active -> cnt=0, LOAD.
  - cnt==end_cnt and not loop_active -> IDLE, done=1.
  - cnt never wraps via increment.
- Abort:
  - set_control with stop=1 while busy sets abort_pending.
  - Abort is honoured only in LOAD or WB; in-flight DMA commands always complete and are written back.
  - Stop=1 in IDLE is ignored.
- Start while busy is ignored. Stop together with start in IDLE: start is taken, stop ignored.
- Latency: set_control start at cycle N -> LOAD at N+1 -> cmd_valid high at N+2.
- All outputs are registered, except slot_rd_index and the cmd addr/size buses, which derive from registers.

Test Plan:
- endCnt=1; start; slot0 src=0x1000/64, dst=0x2000/64; ready=1; done pulses 5 cycles after handshake -> both cmds seen at N+2; slot0 status=2'b10 with profile ≈6; then slot1 runs; final done=1, busy=0.
- Slot0 sizes both 0 -> no cmd_valid; WB status=2'b11, profile=0.
- src_size=0, des_size=32 -> only s2mm_cmd_valid asserted; mm2s_done ignored; completes on s2mm_done.
- mm2s_cmd_ready low 3 cycles, s2mm_cmd_ready=1 -> s2mm_cmd_valid drops after 1 cycle; mm2s_cmd_valid held for 4 cycles with stable addr/size.
- Loop=1, endCnt=3 -> cnt runs 0,1,2,3,0; stop during slot 1 WAIT -> slot 1 written back, then IDLE with aborted=1, done=0.
- Reset asserted during WAIT -> all outputs 0 immediately; after release a start write runs normally from slot 0.

Source files
------------

// File: rtl/seq_ctrl_fsm.sv
// Slot-table sequencer: walks rows 0..end_cnt, issues MM2S/S2MM commands per row,
// waits for both completions, then writes per-slot status and a cycle profile back.
module seq_ctrl_fsm #(
   parameter int INDEX_WIDTH       = 2,
   parameter int SRC_ADDR_WIDTH    = 32,
   parameter int SRC_SIZE_WIDTH    = 26,
   parameter int DST_ADDR_WIDTH    = 32,
   parameter int DST_SIZE_WIDTH    = 26,
   parameter int SLOT_STATUS_WIDTH = 2,
   parameter int PROFILE_WIDTH     = 32,
   parameter int CONTROL_WIDTH     = 4,
   parameter int STATUS_WIDTH      = 4,
   parameter int CNT_WIDTH         = INDEX_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CONTROL_WIDTH-1:0]     inp_control,
   input  logic                         set_control,
   input  logic [CNT_WIDTH-1:0]         inp_endCnt,
   input  logic                         set_endCnt,
   output logic [STATUS_WIDTH-1:0]      bank0_status,
   output logic [CNT_WIDTH-1:0]         cur_cnt,
   output logic [INDEX_WIDTH-1:0]       slot_rd_index,
   input  logic [SRC_ADDR_WIDTH-1:0]    slot_src_addr,
   input  logic [SRC_SIZE_WIDTH-1:0]    slot_src_size,
   input  logic [DST_ADDR_WIDTH-1:0]    slot_des_addr,
   input  logic [DST_SIZE_WIDTH-1:0]    slot_des_size,
   output logic [INDEX_WIDTH-1:0]       slot_wr_index,
   output logic [SLOT_STATUS_WIDTH-1:0] slot_wr_status,
   output logic                         slot_set_status,
   output logic [PROFILE_WIDTH-1:0]     slot_wr_profile,
   output logic                         slot_set_profile,
   output logic                         mm2s_cmd_valid,
   input  logic                         mm2s_cmd_ready,
   output logic [SRC_ADDR_WIDTH-1:0]    mm2s_cmd_addr,
   output logic [SRC_SIZE_WIDTH-1:0]    mm2s_cmd_size,
   output logic                         s2mm_cmd_valid,
   input  logic                         s2mm_cmd_ready,
   output logic [DST_ADDR_WIDTH-1:0]    s2mm_cmd_addr,
   output logic [DST_SIZE_WIDTH-1:0]    s2mm_cmd_size,
   input  logic                         mm2s_done,
   input  logic                         s2mm_done
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMD, S_WAIT, S_WB} state_t;

   localparam logic [SLOT_STATUS_WIDTH-1:0] SLOT_DONE = SLOT_STATUS_WIDTH'(2'b10);
   localparam logic [SLOT_STATUS_WIDTH-1:0] SLOT_SKIP = SLOT_STATUS_WIDTH'(2'b11);

   state_t                         state_q;
   logic [CNT_WIDTH-1:0]           cnt_q;
   logic [CNT_WIDTH-1:0]           end_cnt_q;
   logic [PROFILE_WIDTH-1:0]       prof_q;
   logic [PROFILE_WIDTH-1:0]       prof_d;
   logic                           busy_q;
   logic                           done_q;
   logic                           aborted_q;
   logic                           loop_q;
   logic                           abort_pend_q;
   logic [SRC_ADDR_WIDTH-1:0]      src_addr_q;
   logic [SRC_SIZE_WIDTH-1:0]      src_size_q;
   logic [DST_ADDR_WIDTH-1:0]      des_addr_q;
   logic [DST_SIZE_WIDTH-1:0]      des_size_q;
   logic                           mm2s_vld_q;
   logic                           s2mm_vld_q;
   logic                           mm2s_hs_q;
   logic                           s2mm_hs_q;
   logic                           mm2s_dn_q;
   logic                           s2mm_dn_q;
   logic [INDEX_WIDTH-1:0]         wr_index_q;
   logic [SLOT_STATUS_WIDTH-1:0]   wr_status_q;
   logic [PROFILE_WIDTH-1:0]       wr_profile_q;
   logic                           set_status_q;
   logic                           set_profile_q;

   logic ctl_start, ctl_stop, ctl_loop, ctl_clear;
   logic req_mm2s, req_s2mm;
   logic mm2s_issued, s2mm_issued;
   logic mm2s_fin, s2mm_fin;
   logic last_row;

   assign ctl_start = set_control & inp_control[0];
   assign ctl_stop  = set_control & inp_control[1];
   assign ctl_loop  = inp_control[2];
   assign ctl_clear = set_control & inp_control[3];

   // A zero-size channel is never issued and never waited on.
   assign req_mm2s = (src_size_q != '0);
   assign req_s2mm = (des_size_q != '0);

   assign mm2s_issued = ~req_mm2s | mm2s_hs_q | (mm2s_vld_q & mm2s_cmd_ready);
   assign s2mm_issued = ~req_s2mm | s2mm_hs_q | (s2mm_vld_q & s2mm_cmd_ready);
   assign mm2s_fin    = ~req_mm2s | mm2s_dn_q | (mm2s_hs_q & mm2s_done);
   assign s2mm_fin    = ~req_s2mm | s2mm_dn_q | (s2mm_hs_q & s2mm_done);

   assign last_row = (cnt_q == end_cnt_q);
   assign prof_d   = (&prof_q) ? prof_q : prof_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         end_cnt_q     <= '0;
         prof_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
         loop_q        <= 1'b0;
         abort_pend_q  <= 1'b0;
         src_addr_q    <= '0;
         src_size_q    <= '0;
         des_addr_q    <= '0;
         des_size_q    <= '0;
         mm2s_vld_q    <= 1'b0;
         s2mm_vld_q    <= 1'b0;
         mm2s_hs_q     <= 1'b0;
         s2mm_hs_q     <= 1'b0;
         mm2s_dn_q     <= 1'b0;
         s2mm_dn_q     <= 1'b0;
         wr_index_q    <= '0;
         wr_status_q   <= '0;
         wr_profile_q  <= '0;
         set_status_q  <= 1'b0;
         set_profile_q <= 1'b0;
      end else begin
         set_status_q  <= 1'b0;
         set_profile_q <= 1'b0;
         if (ctl_stop && busy_q) begin
            abort_pend_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (set_endCnt) begin
                  end_cnt_q <= inp_endCnt;
               end
               if (ctl_start) begin
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  loop_q       <= ctl_loop;
                  done_q       <= 1'b0;
                  aborted_q    <= 1'b0;
                  abort_pend_q <= 1'b0;
                  state_q      <= S_LOAD;
               end else if (ctl_clear) begin
                  done_q    <= 1'b0;
                  aborted_q <= 1'b0;
               end
            end

            S_LOAD: begin
               src_addr_q <= slot_src_addr;
               src_size_q <= slot_src_size;
               des_addr_q <= slot_des_addr;
               des_size_q <= slot_des_size;
               mm2s_hs_q  <= 1'b0;
               s2mm_hs_q  <= 1'b0;
               mm2s_dn_q  <= 1'b0;
               s2mm_dn_q  <= 1'b0;
               prof_q     <= '0;
               if (abort_pend_q) begin
                  aborted_q    <= 1'b1;
                  busy_q       <= 1'b0;
                  abort_pend_q <= 1'b0;
                  state_q      <= S_IDLE;
               end else if (slot_src_size == '0 && slot_des_size == '0) begin
                  wr_index_q    <= cnt_q;
                  wr_status_q   <= SLOT_SKIP;
                  wr_profile_q  <= '0;
                  set_status_q  <= 1'b1;
                  set_profile_q <= 1'b1;
                  state_q       <= S_WB;
               end else begin
                  mm2s_vld_q <= (slot_src_size != '0);
                  s2mm_vld_q <= (slot_des_size != '0);
                  state_q    <= S_CMD;
               end
            end

            S_CMD: begin
               prof_q <= prof_d;
               if (mm2s_vld_q && mm2s_cmd_ready) begin
                  mm2s_vld_q <= 1'b0;
                  mm2s_hs_q  <= 1'b1;
               end
               if (s2mm_vld_q && s2mm_cmd_ready) begin
                  s2mm_vld_q <= 1'b0;
                  s2mm_hs_q  <= 1'b1;
               end
               // Fast DMAs may finish a channel before the other has been accepted.
               if (mm2s_hs_q && mm2s_done) begin
                  mm2s_dn_q <= 1'b1;
               end
               if (s2mm_hs_q && s2mm_done) begin
                  s2mm_dn_q <= 1'b1;
               end
               if (mm2s_issued && s2mm_issued) begin
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               prof_q <= prof_d;
               if (mm2s_hs_q && mm2s_done) begin
                  mm2s_dn_q <= 1'b1;
               end
               if (s2mm_hs_q && s2mm_done) begin
                  s2mm_dn_q <= 1'b1;
               end
               if (mm2s_fin && s2mm_fin) begin
                  wr_index_q    <= cnt_q;
                  wr_status_q   <= SLOT_DONE;
                  wr_profile_q  <= prof_d;
                  set_status_q  <= 1'b1;
                  set_profile_q <= 1'b1;
                  state_q       <= S_WB;
               end
            end

            S_WB: begin
               if (abort_pend_q) begin
                  aborted_q    <= 1'b1;
                  busy_q       <= 1'b0;
                  abort_pend_q <= 1'b0;
                  state_q      <= S_IDLE;
               end else if (!last_row) begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= S_LOAD;
               end else if (loop_q) begin
                  cnt_q   <= '0;
                  state_q <= S_LOAD;
               end else begin
                  done_q       <= 1'b1;
                  busy_q       <= 1'b0;
                  abort_pend_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bank0_status     = {loop_q, aborted_q, done_q, busy_q};
   assign cur_cnt          = cnt_q;
   assign slot_rd_index    = cnt_q;
   assign slot_wr_index    = wr_index_q;
   assign slot_wr_status   = wr_status_q;
   assign slot_set_status  = set_status_q;
   assign slot_wr_profile  = wr_profile_q;
   assign slot_set_profile = set_profile_q;
   assign mm2s_cmd_valid   = mm2s_vld_q;
   assign mm2s_cmd_addr    = src_addr_q;
   assign mm2s_cmd_size    = src_size_q;
   assign s2mm_cmd_valid   = s2mm_vld_q;
   assign s2mm_cmd_addr    = des_addr_q;
   assign s2mm_cmd_size    = des_size_q;

endmodule

// File: tb/tb_seq_ctrl_fsm.sv
// Directed bench for seq_ctrl_fsm: slot table and DMA responders modelled here,
// writebacks logged at negedge and compared against hand-computed values.
module tb_seq_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  inp_control;
   logic        set_control;
   logic [1:0]  inp_endCnt;
   logic        set_endCnt;
   logic [3:0]  bank0_status;
   logic [1:0]  cur_cnt;
   logic [1:0]  slot_rd_index;
   logic [31:0] slot_src_addr;
   logic [25:0] slot_src_size;
   logic [31:0] slot_des_addr;
   logic [25:0] slot_des_size;
   logic [1:0]  slot_wr_index;
   logic [1:0]  slot_wr_status;
   logic        slot_set_status;
   logic [31:0] slot_wr_profile;
   logic        slot_set_profile;
   logic        mm2s_cmd_valid;
   logic        mm2s_cmd_ready;
   logic [31:0] mm2s_cmd_addr;
   logic [25:0] mm2s_cmd_size;
   logic        s2mm_cmd_valid;
   logic        s2mm_cmd_ready;
   logic [31:0] s2mm_cmd_addr;
   logic [25:0] s2mm_cmd_size;
   logic        mm2s_done = 1'b0;
   logic        s2mm_done = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_ctrl_fsm dut (
      .clk(clk), .reset(reset),
      .inp_control(inp_control), .set_control(set_control),
      .inp_endCnt(inp_endCnt), .set_endCnt(set_endCnt),
      .bank0_status(bank0_status), .cur_cnt(cur_cnt),
      .slot_rd_index(slot_rd_index),
      .slot_src_addr(slot_src_addr), .slot_src_size(slot_src_size),
      .slot_des_addr(slot_des_addr), .slot_des_size(slot_des_size),
      .slot_wr_index(slot_wr_index), .slot_wr_status(slot_wr_status),
      .slot_set_status(slot_set_status),
      .slot_wr_profile(slot_wr_profile), .slot_set_profile(slot_set_profile),
      .mm2s_cmd_valid(mm2s_cmd_valid), .mm2s_cmd_ready(mm2s_cmd_ready),
      .mm2s_cmd_addr(mm2s_cmd_addr), .mm2s_cmd_size(mm2s_cmd_size),
      .s2mm_cmd_valid(s2mm_cmd_valid), .s2mm_cmd_ready(s2mm_cmd_ready),
      .s2mm_cmd_addr(s2mm_cmd_addr), .s2mm_cmd_size(s2mm_cmd_size),
      .mm2s_done(mm2s_done), .s2mm_done(s2mm_done)
   );

   // Slot table with combinational read
   logic [31:0] t_sa [4];
   logic [25:0] t_ss [4];
   logic [31:0] t_da [4];
   logic [25:0] t_ds [4];
   assign slot_src_addr = t_sa[slot_rd_index];
   assign slot_src_size = t_ss[slot_rd_index];
   assign slot_des_addr = t_da[slot_rd_index];
   assign slot_des_size = t_ds[slot_rd_index];

   // DMA responders: done pulse dly cycles after the handshake cycle
   int   dly_m = 5;
   int   dly_s = 5;
   logic spur_m_en = 1'b0;
   int   cd_m = 0, cd_s = 0, cd_sp = 0;
   always @(negedge clk) begin
      mm2s_done = 1'b0;
      s2mm_done = 1'b0;
      if (cd_m > 0) begin cd_m--; if (cd_m == 0) mm2s_done = 1'b1; end
      if (cd_s > 0) begin cd_s--; if (cd_s == 0) s2mm_done = 1'b1; end
      if (cd_sp > 0) begin cd_sp--; if (cd_sp == 0) mm2s_done = 1'b1; end
      if (mm2s_cmd_valid && mm2s_cmd_ready) cd_m = dly_m;
      if (s2mm_cmd_valid && s2mm_cmd_ready) begin
         cd_s = dly_s;
         if (spur_m_en) cd_sp = 2;
      end
   end

   // Writeback log and valid-cycle counters
   int          wb_n = 0, vm_n = 0, vs_n = 0;
   logic [1:0]  wb_idx [64];
   logic [1:0]  wb_st  [64];
   logic [31:0] wb_pf  [64];
   logic        wb_sp  [64];
   always @(negedge clk) begin
      if (slot_set_status && wb_n < 64) begin
         wb_idx[wb_n] = slot_wr_index;
         wb_st[wb_n]  = slot_wr_status;
         wb_pf[wb_n]  = slot_wr_profile;
         wb_sp[wb_n]  = slot_set_profile;
         wb_n++;
      end
      if (mm2s_cmd_valid) vm_n++;
      if (s2mm_cmd_valid) vs_n++;
   end

   task automatic set_ctrl(input logic [3:0] c);
      @(posedge clk); #1;
      inp_control = c;
      set_control = 1'b1;
      @(posedge clk); #1;
      set_control = 1'b0;
      inp_control = 4'h0;
   endtask

   task automatic set_end(input logic [1:0] v);
      @(posedge clk); #1;
      inp_endCnt = v;
      set_endCnt = 1'b1;
      @(posedge clk); #1;
      set_endCnt = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (bank0_status[0] === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bank0_status[0] !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", nm, bank0_status[0], n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inp_control = 4'h0; set_control = 1'b0;
      inp_endCnt = 2'd0;  set_endCnt = 1'b0;
      mm2s_cmd_ready = 1'b1; s2mm_cmd_ready = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({bank0_status, cur_cnt, slot_rd_index} !== 8'h00) begin
         errors++;
         $display("FAIL reset_status: got %h, want 00", {bank0_status, cur_cnt, slot_rd_index});
      end
      checks++;
      if ({mm2s_cmd_valid, s2mm_cmd_valid, slot_set_status, slot_set_profile} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes: got %b, want 0000",
                  {mm2s_cmd_valid, s2mm_cmd_valid, slot_set_status, slot_set_profile});
      end
      checks++;
      if (mm2s_cmd_addr !== 32'h0 || s2mm_cmd_addr !== 32'h0 || slot_wr_profile !== 32'h0) begin
         errors++;
         $display("FAIL reset_buses: got %h %h %h, want 0", mm2s_cmd_addr, s2mm_cmd_addr, slot_wr_profile);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      int b;
      t_sa[0] = 32'h1000; t_ss[0] = 26'd64; t_da[0] = 32'h2000; t_ds[0] = 26'd64;
      t_sa[1] = 32'h3000; t_ss[1] = 26'd16; t_da[1] = 32'h4000; t_ds[1] = 26'd16;
      dly_m = 5; dly_s = 5;
      set_end(2'd1);
      b = wb_n;
      set_ctrl(4'b0001);
      checks++;
      if ({bank0_status, mm2s_cmd_valid, s2mm_cmd_valid, slot_rd_index} !== {4'b0001, 2'b00, 2'd0}) begin
         errors++;
         $display("FAIL basic_load: status/valids/rd got %b %b%b %0d, want 0001 00 0",
                  bank0_status, mm2s_cmd_valid, s2mm_cmd_valid, slot_rd_index);
      end
      @(posedge clk); #1;
      checks++;
      if ({mm2s_cmd_valid, s2mm_cmd_valid} !== 2'b11) begin
         errors++;
         $display("FAIL basic_cmd_valid: got %b, want 11", {mm2s_cmd_valid, s2mm_cmd_valid});
      end
      checks++;
      if (mm2s_cmd_addr !== 32'h1000 || mm2s_cmd_size !== 26'd64 ||
          s2mm_cmd_addr !== 32'h2000 || s2mm_cmd_size !== 26'd64) begin
         errors++;
         $display("FAIL basic_cmd_fields: got %h/%0d %h/%0d, want 1000/64 2000/64",
                  mm2s_cmd_addr, mm2s_cmd_size, s2mm_cmd_addr, s2mm_cmd_size);
      end
      wait_idle("basic");
      checks++;
      if (wb_n - b !== 2) begin
         errors++;
         $display("FAIL basic_wb_count: got %0d, want 2", wb_n - b);
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({wb_idx[b+i], wb_st[b+i], wb_sp[b+i], wb_pf[b+i]} !== {i[1:0], 2'b10, 1'b1, 32'd6}) begin
               errors++;
               $display("FAIL basic_wb%0d: idx=%0d st=%b sp=%b prof=%0d, want idx=%0d st=10 sp=1 prof=6",
                        i, wb_idx[b+i], wb_st[b+i], wb_sp[b+i], wb_pf[b+i], i);
            end
         end
      end
      checks++;
      if (bank0_status !== 4'b0010 || cur_cnt !== 2'd1) begin
         errors++;
         $display("FAIL basic_final: status=%b cnt=%0d, want 0010 1", bank0_status, cur_cnt);
      end
   endtask

   task automatic test_skip();
      int b, m0, s0;
      t_sa[0] = 32'hAAAA; t_ss[0] = 26'd0; t_da[0] = 32'hBBBB; t_ds[0] = 26'd0;
      set_end(2'd0);
      b = wb_n; m0 = vm_n; s0 = vs_n;
      set_ctrl(4'b1001);
      checks++;
      if (bank0_status !== 4'b0001) begin
         errors++;
         $display("FAIL skip_start_clear: status=%b, want 0001", bank0_status);
      end
      wait_idle("skip");
      checks++;
      if (vm_n - m0 !== 0 || vs_n - s0 !== 0) begin
         errors++;
         $display("FAIL skip_no_cmd: valid cycles mm2s=%0d s2mm=%0d, want 0 0", vm_n - m0, vs_n - s0);
      end
      checks++;
      if (wb_n - b !== 1 || {wb_idx[b], wb_st[b], wb_sp[b], wb_pf[b]} !== {2'd0, 2'b11, 1'b1, 32'd0}) begin
         errors++;
         $display("FAIL skip_wb: n=%0d idx=%0d st=%b sp=%b prof=%0d, want n=1 idx=0 st=11 sp=1 prof=0",
                  wb_n - b, wb_idx[b], wb_st[b], wb_sp[b], wb_pf[b]);
      end
   endtask

   task automatic test_single_chan();
      int b, m0, s0;
      t_sa[0] = 32'h5000; t_ss[0] = 26'd0; t_da[0] = 32'h6000; t_ds[0] = 26'd32;
      dly_s = 5;
      spur_m_en = 1'b1;
      b = wb_n; m0 = vm_n; s0 = vs_n;
      set_ctrl(4'b0001);
      @(posedge clk); #1;
      checks++;
      if ({mm2s_cmd_valid, s2mm_cmd_valid} !== 2'b01 || s2mm_cmd_addr !== 32'h6000 || s2mm_cmd_size !== 26'd32) begin
         errors++;
         $display("FAIL single_cmd: valids=%b addr=%h size=%0d, want 01 6000 32",
                  {mm2s_cmd_valid, s2mm_cmd_valid}, s2mm_cmd_addr, s2mm_cmd_size);
      end
      wait_idle("single");
      spur_m_en = 1'b0;
      checks++;
      if (vm_n - m0 !== 0 || vs_n - s0 !== 1) begin
         errors++;
         $display("FAIL single_valid_cycles: mm2s=%0d s2mm=%0d, want 0 1", vm_n - m0, vs_n - s0);
      end
      checks++;
      if (wb_n - b !== 1 || {wb_st[b], wb_pf[b]} !== {2'b10, 32'd6}) begin
         errors++;
         $display("FAIL single_wb: n=%0d st=%b prof=%0d, want n=1 st=10 prof=6", wb_n - b, wb_st[b], wb_pf[b]);
      end
   endtask

   task automatic test_backpressure();
      int b;
      t_sa[0] = 32'h7000; t_ss[0] = 26'd128; t_da[0] = 32'h8000; t_ds[0] = 26'd128;
      dly_m = 2; dly_s = 2;
      mm2s_cmd_ready = 1'b0;
      b = wb_n;
      set_ctrl(4'b0001);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({mm2s_cmd_valid, s2mm_cmd_valid} !== {1'b1, (k == 0)} ||
             mm2s_cmd_addr !== 32'h7000 || mm2s_cmd_size !== 26'd128) begin
            errors++;
            $display("FAIL bp_hold%0d: valids=%b addr=%h size=%0d, want %b 7000 128",
                     k, {mm2s_cmd_valid, s2mm_cmd_valid}, mm2s_cmd_addr, mm2s_cmd_size, {1'b1, (k == 0)});
         end
      end
      mm2s_cmd_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({mm2s_cmd_valid, s2mm_cmd_valid} !== 2'b00) begin
         errors++;
         $display("FAIL bp_drop: valids=%b, want 00", {mm2s_cmd_valid, s2mm_cmd_valid});
      end
      wait_idle("bp");
      checks++;
      if (wb_n - b !== 1 || {wb_st[b], wb_pf[b]} !== {2'b10, 32'd6}) begin
         errors++;
         $display("FAIL bp_wb: n=%0d st=%b prof=%0d, want n=1 st=10 prof=6", wb_n - b, wb_st[b], wb_pf[b]);
      end
   endtask

   task automatic test_loop_abort();
      int b, n;
      logic [1:0] exp_idx [6];
      exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd2;
      exp_idx[3] = 2'd3; exp_idx[4] = 2'd0; exp_idx[5] = 2'd1;
      for (int i = 0; i < 4; i++) begin
         t_sa[i] = 32'h100 * (i + 1); t_ss[i] = 26'd8;
         t_da[i] = 32'h900 * (i + 1); t_ds[i] = 26'd8;
      end
      dly_m = 3; dly_s = 3;
      set_end(2'd3);
      b = wb_n;
      set_ctrl(4'b0101);
      checks++;
      if (bank0_status !== 4'b1001) begin
         errors++;
         $display("FAIL loop_start: status=%b, want 1001", bank0_status);
      end
      set_end(2'd0);
      n = 0;
      while (wb_n - b < 5 && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (mm2s_cmd_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (mm2s_cmd_valid !== 1'b1 || cur_cnt !== 2'd1) begin
         errors++;
         $display("FAIL loop_reach_slot1: valid=%b cnt=%0d wb=%0d, want 1 1 5", mm2s_cmd_valid, cur_cnt, wb_n - b);
      end
      set_ctrl(4'b0010);
      wait_idle("loop");
      checks++;
      if (wb_n - b !== 6) begin
         errors++;
         $display("FAIL loop_wb_count: got %0d, want 6", wb_n - b);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if ({wb_idx[b+i], wb_st[b+i]} !== {exp_idx[i], 2'b10}) begin
               errors++;
               $display("FAIL loop_wb%0d: idx=%0d st=%b, want idx=%0d st=10", i, wb_idx[b+i], wb_st[b+i], exp_idx[i]);
            end
         end
      end
      checks++;
      if (bank0_status[2:0] !== 3'b100 || cur_cnt !== 2'd1) begin
         errors++;
         $display("FAIL loop_aborted: status=%b cnt=%0d, want x100 1", bank0_status, cur_cnt);
      end
      set_ctrl(4'b1000);
      checks++;
      if (bank0_status[2:0] !== 3'b000) begin
         errors++;
         $display("FAIL clear: status=%b, want x000", bank0_status);
      end
      b = wb_n;
      set_ctrl(4'b0010);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bank0_status[2:0] !== 3'b000 || wb_n !== b) begin
         errors++;
         $display("FAIL idle_stop: status=%b wb=%0d, want x000 0", bank0_status, wb_n - b);
      end
   endtask

   task automatic test_reset_mid();
      int b, n;
      t_sa[0] = 32'hC000; t_ss[0] = 26'd4; t_da[0] = 32'hD000; t_ds[0] = 26'd4;
      dly_m = 20; dly_s = 20;
      set_end(2'd0);
      set_ctrl(4'b0001);
      n = 0;
      while (mm2s_cmd_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      repeat (3) @(posedge clk);
      #1;
      b = wb_n;
      reset = 1'b0;
      #1;
      checks++;
      if ({bank0_status, cur_cnt, mm2s_cmd_valid, s2mm_cmd_valid, slot_set_status, slot_set_profile} !== 10'h0 ||
          mm2s_cmd_addr !== 32'h0 || s2mm_cmd_size !== 26'h0) begin
         errors++;
         $display("FAIL midreset_outputs: status=%b cnt=%0d v=%b%b set=%b%b addr=%h, want all 0",
                  bank0_status, cur_cnt, mm2s_cmd_valid, s2mm_cmd_valid, slot_set_status, slot_set_profile, mm2s_cmd_addr);
      end
      repeat (25) @(negedge clk);
      reset = 1'b1;
      dly_m = 2; dly_s = 2;
      set_ctrl(4'b0001);
      wait_idle("midreset");
      checks++;
      if (wb_n - b !== 1 || {wb_idx[b], wb_st[b], wb_pf[b]} !== {2'd0, 2'b10, 32'd3}) begin
         errors++;
         $display("FAIL midreset_rerun: n=%0d idx=%0d st=%b prof=%0d, want n=1 idx=0 st=10 prof=3",
                  wb_n - b, wb_idx[b], wb_st[b], wb_pf[b]);
      end
      checks++;
      if (bank0_status !== 4'b0010) begin
         errors++;
         $display("FAIL midreset_final: status=%b, want 0010", bank0_status);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_single_chan();
      test_backpressure();
      test_loop_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
